// File: rtl/sqrt_seq_unit.sv
// Sequential integer square root: one result bit per clock using the
// restoring digit-by-digit method; rst low loads the operand, release starts.
module sqrt_seq_unit #(
    parameter int VAL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VAL_W-1:0]   val,
    output logic [VAL_W/2-1:0] out,
    output logic               eop
);

    localparam int OUT_W = VAL_W / 2;
    localparam int CNT_W = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [VAL_W-1:0]   op, op_n;
    logic [OUT_W+1:0]   rem, rem_n;
    logic [OUT_W-1:0]   root, root_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [OUT_W-1:0]   out_n;
    logic               eop_n;

    logic [OUT_W+1:0]   rem_sh;
    logic [OUT_W+1:0]   trial;
    logic               fit;

    // The operand is shifted left each step so its top pair is always next.
    assign rem_sh = (rem << 2) | {{OUT_W{1'b0}}, op[VAL_W-1 -: 2]};
    assign trial  = {root, 2'b01};
    assign fit    = (rem_sh >= trial);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
            op    <= val;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            out   <= '0;
            eop   <= 1'b0;
        end else begin
            state <= state_n;
            op    <= op_n;
            rem   <= rem_n;
            root  <= root_n;
            cnt   <= cnt_n;
            out   <= out_n;
            eop   <= eop_n;
        end
    end

    always_comb begin
        state_n = state;
        op_n    = op;
        rem_n   = rem;
        root_n  = root;
        cnt_n   = cnt;
        out_n   = out;
        eop_n   = eop;
        case (state)
            LOAD, CALC: begin
                op_n   = op << 2;
                rem_n  = fit ? (rem_sh - trial) : rem_sh;
                root_n = {root[OUT_W-2:0], fit};
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(OUT_W - 1)) begin
                    state_n = DONE;
                end else begin
                    state_n = CALC;
                end
            end
            DONE: begin
                out_n = root;
                eop_n = 1'b1;
            end
            // An illegal encoding waits here until the next load.
            default: begin
                state_n = state;
            end
        endcase
    end

endmodule

// File: tb/tb_sqrt_seq_unit.sv
// Bench for sqrt_seq_unit: vector table, scoreboard queue and
// hand-written abort / hold sequences.
module tb_sqrt_seq_unit;

    logic        clk;
    logic        rst;
    logic [31:0] val;
    logic [15:0] out;
    logic        eop;

    typedef struct {
        logic [31:0] v;
        logic [15:0] e;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];

    int nvec;
    int nerr;

    sqrt_seq_unit #(.VAL_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .val(val),
        .out(out),
        .eop(eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] isqrt(input logic [31:0] v);
        logic [63:0] lo, hi, mid;
        lo = 0;
        hi = 64'd65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= {32'd0, v}) lo = mid;
            else hi = mid;
        end
        return lo[15:0];
    endfunction

    // Load v with rst held low for 'low' cycles, then release.
    task automatic start(input logic [31:0] v, input logic [15:0] e,
                         input int low);
        vec_t r;
        @(negedge clk);
        rst = 1'b0;
        val = v;
        repeat (low) @(negedge clk);
        chk("load_eop", {63'd0, eop}, 64'd0);
        chk("load_out", {48'd0, out}, 64'd0);
        rst = 1'b1;
        r.v = v;
        r.e = e;
        sb.push_back(r);
    endtask

    // Wait for eop; it must appear exactly 17 edges after release.
    task automatic finish_op();
        int n;
        vec_t r;
        logic [63:0] o, v64;
        n = 0;
        while (n < 40 && eop !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        if (eop !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL eop_timeout: got no eop, want eop after 17 edges");
            void'(sb.pop_front());
            return;
        end
        chk("latency", 64'(n), 64'd17);
        r = sb.pop_front();
        chk($sformatf("out_%0h", r.v), {48'd0, out}, {48'd0, r.e});
        o = {48'd0, out};
        v64 = {32'd0, r.v};
        chk("bound", {63'd0, (o * o <= v64) && (v64 < (o + 1) * (o + 1))},
            64'd1);
    endtask

    initial begin
        vec_t t;
        logic [15:0] sweep [20];
        logic [31:0] rv;
        nvec = 0;
        nerr = 0;
        rst = 1'b0;
        val = 32'd0;

        sweep = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2,
                  16'd2, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3,
                  16'd3, 16'd3, 16'd4, 16'd4, 16'd4, 16'd4};
        for (int i = 0; i < 20; i++) begin
            t.v = 32'(i);
            t.e = sweep[i];
            tbl.push_back(t);
        end
        t.v = 32'd15;         t.e = 16'd3;     tbl.push_back(t);
        t.v = 32'd16;         t.e = 16'd4;     tbl.push_back(t);
        t.v = 32'd65535;      t.e = 16'd255;   tbl.push_back(t);
        t.v = 32'd65536;      t.e = 16'd256;   tbl.push_back(t);
        t.v = 32'hFFFF_FFFF;  t.e = 16'hFFFF;  tbl.push_back(t);
        t.v = 32'hFFFE_0001;  t.e = 16'hFFFF;  tbl.push_back(t);
        t.v = 32'hFFFE_0000;  t.e = 16'hFFFE;  tbl.push_back(t);
        t.v = 32'd1000000;    t.e = 16'd1000;  tbl.push_back(t);

        // Two-cycle load of zero first.
        start(32'd0, 16'd0, 2);
        finish_op();

        foreach (tbl[i]) begin
            start(tbl[i].v, tbl[i].e, 1);
            finish_op();
        end

        // Abort at calculation edge 8 with a new operand.
        start(32'd100, 16'd10, 1);
        void'(sb.pop_front());
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_eop", {63'd0, eop}, 64'd0);
        end
        rst = 1'b0;
        val = 32'd49;
        @(negedge clk);
        chk("abort_eop", {63'd0, eop}, 64'd0);
        chk("abort_out", {48'd0, out}, 64'd0);
        rst = 1'b1;
        t.v = 32'd49;
        t.e = 16'd7;
        sb.push_back(t);
        finish_op();

        // Hold in DONE while val toggles.
        start(32'd81, 16'd9, 1);
        finish_op();
        for (int k = 0; k < 20; k++) begin
            val = $urandom;
            @(negedge clk);
            chk("hold_eop", {63'd0, eop}, 64'd1);
            chk("hold_out", {48'd0, out}, 64'd9);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rel_eop", {63'd0, eop}, 64'd0);
        chk("rel_out", {48'd0, out}, 64'd0);

        for (int k = 0; k < 30; k++) begin
            rv = $urandom;
            start(rv, isqrt(rv), 1);
            finish_op();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
